// File: rtl/rv_mem_arb_if.sv
// Bus bundle between the rv32 fetch/load-store requesters, the shared memory
// port and the arbiter that multiplexes them.
interface rv_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ma_req;
    logic              ma_we;
    logic [ADDR_W-1:0] ma_addr;
    logic [DATA_W-1:0] ma_wdata;
    logic              ma_gnt;
    logic              ma_rvalid;
    logic [DATA_W-1:0] ma_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ma_req, ma_we, ma_addr, ma_wdata,
        output ma_gnt, ma_rvalid, ma_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rvalid, mem_rdata
    );

    // Requesters plus memory, as seen from outside the arbiter
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ma_req, ma_we, ma_addr, ma_wdata,
        input  ma_gnt, ma_rvalid, ma_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/rv_mem_arb.sv
// Shares one memory port between instruction fetch and load/store. Data wins
// by default; a saturating starvation counter forces a fetch through.
module rv_mem_arb #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    rv_mem_arb_if.slave         bus,
    output logic                busy
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_MA = 1'b1;
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [0:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;

    logic sel_ma;
    logic grant;
    logic rsp;

    always_comb begin
        sel_ma = bus.ma_req && !(bus.if_req && (starve_cnt_q == MAX_WAIT_C));

        bus.mem_req   = (state_q == S_IDLE) && (bus.if_req || bus.ma_req);
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (bus.mem_req) begin
            if (sel_ma) begin
                bus.mem_we    = bus.ma_we;
                bus.mem_addr  = bus.ma_addr;
                bus.mem_wdata = bus.ma_wdata;
            end else begin
                bus.mem_addr  = bus.if_addr;
            end
        end

        grant      = bus.mem_req && bus.mem_ack;
        bus.ma_gnt = grant && sel_ma;
        bus.if_gnt = grant && !sel_ma;

        // A response only counts while a transaction is outstanding
        rsp           = (state_q == S_WAIT) && bus.mem_rvalid;
        bus.if_rvalid = rsp && (owner_q == OWN_IF);
        bus.ma_rvalid = rsp && (owner_q == OWN_MA);
        bus.if_rdata  = bus.mem_rdata;
        bus.ma_rdata  = bus.mem_rdata;

        busy = (state_q == S_WAIT);
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        if (grant) begin
            state_d = S_WAIT;
            owner_d = sel_ma ? OWN_MA : OWN_IF;
            if (sel_ma && bus.if_req) begin
                if (starve_cnt_q != MAX_WAIT_C) begin
                    starve_cnt_d = starve_cnt_q + 8'd1;
                end
            end else begin
                starve_cnt_d = '0;
            end
        end else if (rsp) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule
